// File: rtl/hsst_sync_fifo_ctrl.sv
// Single-clock FIFO controller with registered level flags, sticky
// overflow/underflow, optional output register and synchronous flush.
module hsst_sync_fifo_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH_WIDTH  = 8,
    parameter int OUTPUT_REG   = 0,
    parameter int ERR_CLR_PRIO = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_en,
    output logic                   wr_full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic                   rd_empty,
    output logic                   almost_empty,
    input  logic [DEPTH_WIDTH:0]   afull_thresh,
    input  logic [DEPTH_WIDTH:0]   aempty_thresh,
    output logic [DEPTH_WIDTH:0]   water_level,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   clr_err
);

    localparam int DEPTH = 2 ** DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] C_DEPTH = {1'b1, {DEPTH_WIDTH{1'b0}}};
    localparam logic [DEPTH_WIDTH:0] C_ONE   = {{DEPTH_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [DEPTH_WIDTH:0]   r_wptr;
    logic [DEPTH_WIDTH:0]   r_rptr;
    logic [DEPTH_WIDTH:0]   r_level;
    logic                   r_full;
    logic                   r_empty;
    logic                   r_afull;
    logic                   r_aempty;
    logic                   r_ovf;
    logic                   r_udf;
    logic [DATA_WIDTH-1:0]  r_s1_data;
    logic                   r_s1_vld;

    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic                   w_ovf_ev;
    logic                   w_udf_ev;
    logic                   w_ovf_nxt;
    logic                   w_udf_nxt;
    logic [DEPTH_WIDTH:0]   w_level_nxt;
    logic [DATA_WIDTH-1:0]  w_rd_word;

    // Flush outranks both requests, so nothing is accepted or flagged.
    assign w_wr_acc = wr_en & ~r_full & ~flush;
    assign w_rd_acc = rd_en & ~r_empty & ~flush;
    assign w_ovf_ev = wr_en & r_full & ~flush;
    assign w_udf_ev = rd_en & r_empty & ~flush;

    assign w_rd_word = r_mem[r_rptr[DEPTH_WIDTH-1:0]];

    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_nxt = r_level + C_ONE;
            2'b01:   w_level_nxt = r_level - C_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    always_comb begin
        w_ovf_nxt = r_ovf;
        w_udf_nxt = r_udf;
        if (ERR_CLR_PRIO != 0) begin
            if (clr_err) begin
                w_ovf_nxt = 1'b0;
                w_udf_nxt = 1'b0;
            end else begin
                w_ovf_nxt = r_ovf | w_ovf_ev;
                w_udf_nxt = r_udf | w_udf_ev;
            end
        end else begin
            w_ovf_nxt = w_ovf_ev | (r_ovf & ~clr_err);
            w_udf_nxt = w_udf_ev | (r_udf & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr[DEPTH_WIDTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else if (flush) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + C_ONE;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + C_ONE;
            end
            r_level  <= w_level_nxt;
            r_full   <= (w_level_nxt == C_DEPTH);
            r_empty  <= (w_level_nxt == '0);
            r_afull  <= (w_level_nxt >= afull_thresh);
            r_aempty <= (w_level_nxt <= aempty_thresh);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_nxt;
            r_udf <= w_udf_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_data <= '0;
            r_s1_vld  <= 1'b0;
        end else if (flush) begin
            r_s1_data <= '0;
            r_s1_vld  <= 1'b0;
        end else begin
            r_s1_vld <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] r_s2_data;
            logic                  r_s2_vld;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s2_data <= '0;
                    r_s2_vld  <= 1'b0;
                end else if (flush) begin
                    r_s2_data <= '0;
                    r_s2_vld  <= 1'b0;
                end else begin
                    r_s2_vld <= r_s1_vld;
                    if (r_s1_vld) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign rd_data  = r_s2_data;
            assign rd_valid = r_s2_vld;
        end else begin : g_noreg
            assign rd_data  = r_s1_data;
            assign rd_valid = r_s1_vld;
        end
    endgenerate

    assign wr_full      = r_full;
    assign rd_empty     = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign water_level  = r_level;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule
